// File: rtl/ps2_kbd_rx.sv
// PS/2 keyboard receiver: synchronise/filter the pins, deserialise 11-bit frames,
// queue good scancodes in a small FIFO and present them with a level handshake.
module ps2_kbd_rx #(
  parameter int FIFO_AW     = 3,
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       KBDread,
  output logic       KBDready,
  output logic [7:0] scancode,
  output logic       overflow,
  output logic       frame_err
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam int CW    = FIFO_AW + 1;
  localparam int FW    = $clog2(FILTER_LEN + 1);
  localparam int TW    = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {RX_IDLE, RX_DATA, RX_PARITY, RX_STOP} rx_state_e;
  typedef enum logic {HS_ARMED, HS_WAIT_LOW} hs_state_e;

  rx_state_e rx_state_q, rx_state_d;
  hs_state_e hs_state_q, hs_state_d;

  logic              clk_s1_q, clk_s1_d, clk_s2_q, clk_s2_d;
  logic              dat_s1_q, dat_s1_d, dat_s2_q, dat_s2_d;
  logic              filt_clk_q, filt_clk_d;
  logic [FW-1:0]     filt_cnt_q, filt_cnt_d;
  logic [2:0]        bitcnt_q, bitcnt_d;
  logic [7:0]        shift_q, shift_d;
  logic              par_q, par_d;
  logic [TW-1:0]     to_cnt_q, to_cnt_d;
  logic [7:0]        mem_q [DEPTH];
  logic [7:0]        mem_d [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              overflow_q, overflow_d;
  logic              frame_err_q, frame_err_d;

  logic bit_edge, timeout, push, frame_bad, pop, full, wr_en;

  // Synchroniser and clock glitch filter; a bit edge is the filtered 1->0 change.
  always_comb begin
    clk_s1_d   = ps2_clk;
    clk_s2_d   = clk_s1_q;
    dat_s1_d   = ps2_data;
    dat_s2_d   = dat_s1_q;
    filt_clk_d = filt_clk_q;
    filt_cnt_d = filt_cnt_q;
    if (clk_s2_q == filt_clk_q) begin
      filt_cnt_d = '0;
    end else if (filt_cnt_q == FW'(FILTER_LEN - 1)) begin
      filt_clk_d = clk_s2_q;
      filt_cnt_d = '0;
    end else begin
      filt_cnt_d = filt_cnt_q + 1'b1;
    end
    bit_edge = filt_clk_q & ~filt_clk_d;
  end

  assign timeout = (rx_state_q != RX_IDLE) && !bit_edge &&
                   (to_cnt_q == TW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk) begin
    if (rst) rx_state_q <= RX_IDLE;
    else     rx_state_q <= rx_state_d;
  end

  always_comb begin
    rx_state_d = rx_state_q;
    if (timeout) begin
      rx_state_d = RX_IDLE;
    end else if (bit_edge) begin
      case (rx_state_q)
        RX_IDLE:   if (!dat_s2_q) rx_state_d = RX_DATA;
        RX_DATA:   if (bitcnt_q == 3'd7) rx_state_d = RX_PARITY;
        RX_PARITY: rx_state_d = RX_STOP;
        default:   rx_state_d = RX_IDLE;
      endcase
    end
  end

  always_comb begin
    push        = (rx_state_q == RX_STOP) && bit_edge && dat_s2_q && (^shift_q ^ par_q);
    frame_bad   = (rx_state_q == RX_STOP) && bit_edge && !push;
    frame_err_d = frame_bad | timeout;
  end

  // Receive datapath: shift register, parity capture and inactivity counter.
  always_comb begin
    bitcnt_d = bitcnt_q;
    shift_d  = shift_q;
    par_d    = par_q;
    to_cnt_d = (rx_state_q == RX_IDLE || bit_edge) ? '0 : to_cnt_q + 1'b1;
    if (bit_edge) begin
      case (rx_state_q)
        RX_IDLE:   bitcnt_d = '0;
        RX_DATA: begin
          shift_d  = {dat_s2_q, shift_q[7:1]};
          bitcnt_d = bitcnt_q + 1'b1;
        end
        RX_PARITY: par_d = dat_s2_q;
        default:   ;
      endcase
    end
  end

  // FIFO; a push into a full FIFO still lands if the head is popped that cycle.
  always_comb begin
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    full       = (count_q == CW'(DEPTH));
    pop        = (hs_state_q == HS_ARMED) && KBDread && (count_q != '0);
    wr_en      = push && (!full || pop);
    overflow_d = overflow_q | (push && !wr_en);
    if (wr_en) begin
      mem_d[wr_ptr_q] = shift_q;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
    count_d = count_q + CW'(wr_en) - CW'(pop);
  end

  always_ff @(posedge clk) begin
    if (rst) hs_state_q <= HS_ARMED;
    else     hs_state_q <= hs_state_d;
  end

  always_comb begin
    hs_state_d = hs_state_q;
    case (hs_state_q)
      HS_ARMED:    if (pop) hs_state_d = HS_WAIT_LOW;
      HS_WAIT_LOW: if (!KBDread) hs_state_d = HS_ARMED;
      default:     hs_state_d = HS_ARMED;
    endcase
  end

  always_comb begin
    KBDready  = (count_q != '0) && (hs_state_q == HS_ARMED);
    scancode  = mem_q[rd_ptr_q];
    overflow  = overflow_q;
    frame_err = frame_err_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      clk_s1_q    <= 1'b1;
      clk_s2_q    <= 1'b1;
      dat_s1_q    <= 1'b1;
      dat_s2_q    <= 1'b1;
      filt_clk_q  <= 1'b1;
      filt_cnt_q  <= '0;
      bitcnt_q    <= '0;
      shift_q     <= '0;
      par_q       <= 1'b0;
      to_cnt_q    <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      clk_s1_q    <= clk_s1_d;
      clk_s2_q    <= clk_s2_d;
      dat_s1_q    <= dat_s1_d;
      dat_s2_q    <= dat_s2_d;
      filt_clk_q  <= filt_clk_d;
      filt_cnt_q  <= filt_cnt_d;
      bitcnt_q    <= bitcnt_d;
      shift_q     <= shift_d;
      par_q       <= par_d;
      to_cnt_q    <= to_cnt_d;
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      frame_err_q <= frame_err_d;
    end
  end

endmodule

// File: tb/tb_ps2_kbd_rx.sv
// Bench for ps2_kbd_rx: a PS/2 device model drives frames, a bus model reads
// scancodes, and a byte-queue reference model predicts what the bus must see.
module tb_ps2_kbd_rx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       KBDread = 1'b0;
  logic       KBDready;
  logic [7:0] scancode;
  logic       overflow;
  logic       frame_err;

  int checks = 0;
  int errors = 0;
  int err_cnt = 0;

  logic [7:0] exp_q[$];
  logic       model_ovf = 1'b0;
  event       stop_fall_ev;

  ps2_kbd_rx #(.FIFO_AW(3), .FILTER_LEN(8), .TIMEOUT_CYC(2000)) dut (
    .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .KBDread(KBDread), .KBDready(KBDready), .scancode(scancode),
    .overflow(overflow), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (!rst && frame_err) err_cnt <= err_cnt + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, actual=hang required=finish");
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic ps2_bit(input logic b, input bit is_stop);
    ps2_data = b;
    tick(25);
    ps2_clk = 1'b0;
    if (is_stop) -> stop_fall_ev;
    tick(50);
    ps2_clk = 1'b1;
    tick(25);
  endtask

  task automatic send_frame(input logic [7:0] b, input bit flip_par, input logic stop_b);
    logic par;
    par = ($countones(b) % 2 == 0) ? 1'b1 : 1'b0;
    if (flip_par) par = ~par;
    ps2_bit(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i], 1'b0);
    ps2_bit(par, 1'b0);
    ps2_bit(stop_b, 1'b1);
    ps2_data = 1'b1;
    tick(100);
  endtask

  task automatic model_push(input logic [7:0] b);
    if (exp_q.size() < 8) exp_q.push_back(b);
    else model_ovf = 1'b1;
  endtask

  task automatic good(input logic [7:0] b);
    send_frame(b, 1'b0, 1'b1);
    model_push(b);
  endtask

  task automatic do_read(input string name);
    logic [7:0] exp;
    for (int i = 0; i < 3000 && !KBDready; i++) tick(1);
    checks++;
    if (!KBDready) begin
      errors++;
      $display("FAIL %s ready_wait: KBDready=%0b required=1", name, KBDready);
      return;
    end
    if (exp_q.size() == 0) exp = 8'hxx;
    else exp = exp_q.pop_front();
    checks++;
    if (scancode !== exp) begin
      errors++;
      $display("FAIL %s scancode: actual=%02h required=%02h", name, scancode, exp);
    end
    KBDread = 1'b1;
    tick(1);
    checks++;
    if (KBDready !== 1'b0) begin
      errors++;
      $display("FAIL %s ready_after_read: actual=%0b required=0", name, KBDready);
    end
    tick($urandom_range(1, 4));
    checks++;
    if (KBDready !== 1'b0) begin
      errors++;
      $display("FAIL %s ready_while_read_high: actual=%0b required=0", name, KBDready);
    end
    KBDread = 1'b0;
    tick(1);
  endtask

  task automatic check_idle(input string name);
    tick(20);
    checks++;
    if (KBDready !== 1'b0) begin
      errors++;
      $display("FAIL %s empty: KBDready=%0b required=0", name, KBDready);
    end
  endtask

  task automatic check_err(input string name, input int base, input int delta);
    checks++;
    if (err_cnt - base !== delta) begin
      errors++;
      $display("FAIL %s frame_err_cycles: actual=%0d required=%0d", name, err_cnt - base, delta);
    end
  endtask

  task automatic test_reset(input string name);
    checks++;
    if ({KBDready, scancode, overflow, frame_err} !== 11'h000) begin
      errors++;
      $display("FAIL %s outputs: actual ready=%0b code=%02h ovf=%0b err=%0b required all 0",
               name, KBDready, scancode, overflow, frame_err);
    end
  endtask

  task automatic test_single();
    int base = err_cnt;
    KBDread = 1'b1;
    tick(5);
    KBDread = 1'b0;
    tick(2);
    good(8'h1C);
    check_err("single", base, 0);
    do_read("single");
    check_idle("single");
  endtask

  task automatic test_burst();
    good(8'hF0);
    good(8'h1C);
    do_read("burst0");
    do_read("burst1");
    check_idle("burst");
  endtask

  task automatic test_bad_frames();
    int base = err_cnt;
    send_frame(8'h1C, 1'b1, 1'b1);
    check_err("bad_parity", base, 1);
    check_idle("bad_parity");
    base = err_cnt;
    send_frame(8'h1C, 1'b0, 1'b0);
    check_err("bad_stop", base, 1);
    check_idle("bad_stop");
  endtask

  task automatic test_overflow();
    for (int i = 1; i <= 9; i++) good(8'(i));
    checks++;
    if (overflow !== model_ovf || model_ovf !== 1'b1) begin
      errors++;
      $display("FAIL overflow flag: actual=%0b required=%0b", overflow, model_ovf);
    end
    for (int i = 0; i < 8; i++) do_read("overflow_drain");
    check_idle("overflow");
  endtask

  task automatic test_timeout();
    int base = err_cnt;
    ps2_bit(1'b0, 1'b0);
    ps2_bit(1'b1, 1'b0);
    ps2_bit(1'b0, 1'b0);
    ps2_bit(1'b1, 1'b0);
    tick(2200);
    check_err("timeout", base, 1);
    check_idle("timeout");
    good(8'h29);
    do_read("after_timeout");
  endtask

  task automatic test_glitch();
    int base = err_cnt;
    ps2_data = 1'b0;
    tick(10);
    ps2_clk = 1'b0;
    tick(3);
    ps2_clk = 1'b1;
    tick(5);
    ps2_data = 1'b1;
    tick(2500);
    check_err("glitch", base, 0);
    check_idle("glitch");
    good(8'h5A);
    do_read("after_glitch");
  endtask

  task automatic test_reset_mid();
    int base;
    good(8'h11);
    good(8'h22);
    ps2_bit(1'b0, 1'b0);
    ps2_bit(1'b1, 1'b0);
    ps2_bit(1'b1, 1'b0);
    rst = 1'b1;
    tick(2);
    test_reset("reset_mid");
    rst = 1'b0;
    exp_q.delete();
    model_ovf = 1'b0;
    tick(2);
    base = err_cnt;
    good(8'h1C);
    do_read("after_reset");
    tick(2500);
    check_err("after_reset", base, 0);
    check_idle("after_reset");
  endtask

  // Sweep the read around the push so one offset lands on the same cycle.
  task automatic test_push_pop();
    for (int off = 6; off <= 12; off++) begin
      logic [7:0] a, b;
      a = 8'($urandom);
      b = 8'($urandom);
      good(a);
      fork
        begin
          send_frame(b, 1'b0, 1'b1);
          model_push(b);
        end
        begin
          logic [7:0] e;
          @(stop_fall_ev);
          tick(off);
          e = exp_q.pop_front();
          checks++;
          if (KBDready !== 1'b1 || scancode !== e) begin
            errors++;
            $display("FAIL push_pop head off=%0d: ready=%0b code=%02h required ready=1 code=%02h",
                     off, KBDready, scancode, e);
          end
          KBDread = 1'b1;
          tick(1);
          KBDread = 1'b0;
        end
      join
      do_read("push_pop_second");
      check_idle("push_pop");
    end
  endtask

  task automatic test_random();
    int base = err_cnt;
    int nbad = 0;
    for (int i = 0; i < 10; i++) begin
      logic [7:0] b;
      int kind;
      b = 8'($urandom);
      kind = $urandom_range(0, 9);
      if (kind < 7) good(b);
      else if (kind == 7) begin send_frame(b, 1'b1, 1'b1); nbad++; end
      else begin send_frame(b, 1'b0, 1'b0); nbad++; end
      if ($urandom_range(0, 1) == 1 && exp_q.size() > 0) do_read("random");
    end
    while (exp_q.size() > 0) do_read("random_drain");
    check_idle("random");
    check_err("random", base, nbad);
    checks++;
    if (overflow !== model_ovf) begin
      errors++;
      $display("FAIL random overflow: actual=%0b required=%0b", overflow, model_ovf);
    end
  endtask

  initial begin
    rst = 1'b1;
    tick(3);
    test_reset("reset");
    rst = 1'b0;
    tick(2);
    test_single();
    test_burst();
    test_bad_frames();
    test_overflow();
    test_timeout();
    test_glitch();
    test_reset_mid();
    test_push_pop();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ps2_kbd_rx.md
Name: ps2_kbd_rx

Overview:
PS/2 keyboard receiver that deserialises 11-bit device-to-host frames and checks start, odd parity and stop bits. Good scancodes are queued in a small FIFO. It sits directly upstream of the I/O bus and drives its keyboard inputs (KBDready, scancode). The bus returns KBDread using a level handshake: KBDread rises on a CPU read while KBDready is high, and falls only after KBDready drops.

Parameters:
FIFO_AW, 3, log2 of FIFO depth (default 8 entries)
FILTER_LEN, 8, consecutive equal clk samples needed to accept a PS/2 line change
TIMEOUT_CYC, 100000, clk cycles without a PS/2 falling edge before a partial frame is abandoned

Ports:
clk  input  1  system clock
rst  input  1  reset, synchronous, active-high
ps2_clk  input  1  raw PS/2 clock from pin, asynchronous
ps2_data  input  1  raw PS/2 data from pin, asynchronous
KBDread  input  1  read acknowledge from I/O bus (registered on its side)
KBDready  output  1  FIFO head valid and armed for the bus
scancode  output  8  FIFO head byte
overflow  output  1  sticky: a good frame was dropped because the FIFO was full
frame_err  output  1  one-cycle pulse on a parity, stop or timeout error

Behaviour:
- Reset:
  - KBDready=0, scancode=8'h00, overflow=0, frame_err=0.
  - FIFO pointers and count=0, FIFO storage cleared.
  - Receive FSM=IDLE, handshake FSM=ARMED.
  - A reset mid-frame discards the partial frame.
- Input conditioning:
  - 2-FF synchroniser on ps2_clk and ps2_data.
  - Filtered clock changes only after FILTER_LEN consecutive identical synchronised samples.
  - A filtered-clock 1->0 transition is a "bit edge"; data is sampled from the synchronised ps2_data on that cycle.
- Receive FSM (all transitions on bit edges except timeout):
  - IDLE: data=0 -> DATA with bitcnt=0; data=1 -> stay in IDLE (spurious edge ignored).
  - DATA: shift LSB first; after the 8th bit -> PARITY.
  - PARITY: capture the parity bit -> STOP.
  - STOP: frame is good when data=1 and (^byte ^ parity)=1. Good -> push; otherwise pulse frame_err. Either way -> IDLE.
  - Timeout: in any non-IDLE state, a counter is cleared on every bit edge. When it reaches TIMEOUT_CYC -> IDLE, with a frame_err pulse.
- FIFO:
  - Depth 2^FIFO_AW, register based.
  - Push occurs on the STOP-edge cycle.
  - Push when full: byte dropped, overflow<=1 (held until rst).
  - Simultaneous push and pop: both take effect, count unchanged. This holds even when full.
  - scancode = mem[rd_ptr] (combinational read of registered state); it is stable while KBDready=1.
- Handshake FSM:
  - KBDready = (count!=0) && state==ARMED.
  - ARMED: KBDread=1 && count!=0 -> pop once, go to WAIT_LOW. KBDready is 0 from the next cycle.
  - WAIT_LOW: no pops. KBDread=0 -> ARMED.
  - A KBDread that is still high from an earlier read never causes a second pop.
- Latency:
  - A byte becomes visible on KBDready the cycle after its push, if the FIFO was empty and the FSM is ARMED.
  - The next entry is presented at the earliest 2 cycles after the pop (WAIT_LOW -> ARMED).
- Invalid conditions:
  - KBDread=1 with an empty FIFO in ARMED: ignored, no pointer change.

Test Plan:
- Bench settings: clk model; PS/2 half-period 50 clk, FILTER_LEN=8, TIMEOUT_CYC=2000 for simulation.
- Single frame 0x1C (parity 0, stop 1) -> KBDready=1 with scancode=8'h1C one cycle after the stop edge. A bus model raises KBDread -> KBDready=0 next cycle, count=0, and it stays 0 after KBDread falls.
- Burst F0 (parity 1) then 1C with no reads -> count=2. The first read gives 8'hF0. KBDready stays low until KBDread=0, then goes high with 8'h1C. The second read empties the FIFO.
- Frame 0x1C with parity bit 1 -> one frame_err pulse, no push, KBDready stays 0. Repeat with stop bit 0 -> same result.
- 9 good frames 0x01..0x09, no reads -> overflow=1 after the 9th. Reads return 0x01..0x08 in order, then KBDready=0.
- Timeout and glitch:
  - Start bit plus 3 data bits, then ps2_clk held high for 2000+ cycles -> frame_err pulse, FSM in IDLE. The next frame 0x29 is received intact.
  - A 3-cycle low glitch on ps2_clk -> no bit sampled.
- Reset and simultaneous events:
  - rst asserted mid-frame and with 2 entries queued -> all outputs return to reset values. A following 0x1C frame is received correctly.
  - A push landing in the same cycle as a pop -> count unchanged.
